// File: rtl/wb_copy_if.sv
// Wishbone classic link between the block-copy initiator (master) and a memory responder (slave).
// Handshake: a request is live while cyc=stb=1. It completes on the rising edge where ack=1 is sampled
// with stb high, and the initiator drops stb at that same edge. An ack seen while stb is low means nothing.
interface wb_copy_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator that copies cfg_len 32-bit words from src to dst as read/write pairs,
// with a per-transfer ack timeout. All outputs come straight from flops.
module wb_copy_master #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_src_adr,
    input  logic [31:0]      cfg_dst_adr,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] xfer_cnt,
    output logic [2:0]       dbg_state,
    wb_copy_if.master        wbm
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_GAP, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d, dst_q, dst_d, data_q, data_d;
    logic [LEN_W-1:0]   rem_q, rem_d, cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               cyc_q, cyc_d, we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d, dat_o_q, dat_o_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_o_q <= dat_o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_o_d = dat_o_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    src_d  = cfg_src_adr & 32'hFFFF_FFFC;
                    dst_d  = cfg_dst_adr & 32'hFFFF_FFFC;
                    rem_d  = cfg_len;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (cfg_len == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = 4'hF;
                        adr_d   = cfg_src_adr & 32'hFFFF_FFFC;
                        wait_d  = '0;
                    end
                end
            end
            S_RD: begin
                // ack wins over a timeout expiring on the same edge
                if (cyc_q && wbm.wbm_ack_i) begin
                    data_d  = wbm.wbm_dat_i;
                    cyc_d   = 1'b0;
                    sel_d   = 4'h0;
                    state_d = S_WR;
                end else if (cyc_q && wait_q == WAIT_MAX) begin
                    cyc_d   = 1'b0;
                    sel_d   = 4'h0;
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (cyc_q) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WR: begin
                // First WR cycle is the bus-idle gap after the read ack; the write request starts after it.
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = 4'hF;
                    adr_d   = dst_q;
                    dat_o_d = data_q;
                    wait_d  = '0;
                end else if (wbm.wbm_ack_i) begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    rem_d   = rem_q - LEN_W'(1);
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    state_d = S_GAP;
                end else if (wait_q == WAIT_MAX) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                if (rem_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RD;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    adr_d   = src_q;
                    wait_d  = '0;
                end
            end
            S_FIN: begin
                // done is high for one cycle; busy falls on the edge that ends it
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign xfer_cnt      = cnt_q;
    assign dbg_state     = state_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_o_q;
endmodule
